usb_pulpino_mbox_ctrl: RTL and testbench

USB_PULPINO_MBOX_CTRL -- requirements
Module: usb_pulpino_mbox_ctrl

---
 rtl/usb_pulpino_pkg.sv | 16 +
 rtl/flicker_edge_det.sv | 18 +
 rtl/usb_pulpino_mbox_ctrl.sv | 166 ++++++++++++++++
 tb/tb_usb_pulpino_mbox_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/usb_pulpino_pkg.sv
// rtl/usb_pulpino_pkg.sv - shared types and constants for the USB/EXT to Pulpino mailbox
package usb_pulpino_pkg;

  localparam int MBOX_DATA_W = 8;

  localparam logic OWNER_USB = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DELIVER  = 2'd3
  } mbox_state_t;

endpackage

// File: rtl/flicker_edge_det.sv
// rtl/flicker_edge_det.sv - reports any change of a toggle-style flicker line
module flicker_edge_det (
  input  logic clk,
  input  logic reset_i,
  input  logic flicker_i,
  output logic event_o
);

  logic prev_q;

  // Loading the live value during reset hides whatever level the line sits at.
  always_ff @(posedge clk) begin
    prev_q <= flicker_i;
  end

  assign event_o = ~reset_i & (flicker_i ^ prev_q);

endmodule

// File: rtl/usb_pulpino_mbox_ctrl.sv
// rtl/usb_pulpino_mbox_ctrl.sv - round-robin USB/EXT byte mailbox to Pulpino over flicker handshakes
// Optional response timeout is compiled in with MBOX_TIMEOUT_EN.
module usb_pulpino_mbox_ctrl
  import usb_pulpino_pkg::*;
#(
  parameter int DATA_W         = MBOX_DATA_W,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              usb_req_valid_i,
  output logic              usb_req_ready_o,
  input  logic [DATA_W-1:0] usb_req_data_i,
  output logic              usb_rsp_valid_o,
  input  logic              usb_rsp_ready_i,
  output logic [DATA_W-1:0] usb_rsp_data_o,
  output logic              usb_rsp_err_o,
  input  logic              ext_req_valid_i,
  output logic              ext_req_ready_o,
  input  logic [DATA_W-1:0] ext_req_data_i,
  output logic              ext_rsp_valid_o,
  input  logic              ext_rsp_ready_i,
  output logic [DATA_W-1:0] ext_rsp_data_o,
  output logic              ext_rsp_err_o,
  output logic [DATA_W-1:0] p_data_o,
  output logic              p_wr_flicker_o,
  input  logic              p_rd_flicker_i,
  input  logic [DATA_W-1:0] p_data_i,
  input  logic              p_wr_flicker_i,
  output logic              p_rd_flicker_o,
  output logic              busy_o,
  output logic              owner_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  mbox_state_t       state_q, state_nxt;
  logic              owner_q, last_served_q;
  logic [DATA_W-1:0] p_data_q, rsp_data_q;
  logic              wr_flk_q, rd_flk_q, rsp_err;
  logic              ack_evt, rsp_evt, timeout;
  logic              grant_usb, grant_ext, capture, timeout_fire, rsp_ready;

  flicker_edge_det u_ack_det (
    .clk      (clk),
    .reset_i  (reset_i),
    .flicker_i(p_rd_flicker_i),
    .event_o  (ack_evt)
  );

  flicker_edge_det u_rsp_det (
    .clk      (clk),
    .reset_i  (reset_i),
    .flicker_i(p_wr_flicker_i),
    .event_o  (rsp_evt)
  );

  always_comb begin
    state_nxt    = state_q;
    grant_usb    = 1'b0;
    grant_ext    = 1'b0;
    capture      = 1'b0;
    timeout_fire = 1'b0;
    rsp_ready    = (owner_q == OWNER_EXT) ? ext_rsp_ready_i : usb_rsp_ready_i;
    case (state_q)
      ST_IDLE: begin
        if (usb_req_valid_i && (!ext_req_valid_i || last_served_q == OWNER_EXT)) grant_usb = 1'b1;
        else if (ext_req_valid_i) grant_ext = 1'b1;
        if (grant_usb || grant_ext) state_nxt = ST_SEND;
      end
      // A response also implies the byte was consumed, so it wins over the ack.
      ST_SEND: begin
        if (rsp_evt) begin
          capture   = 1'b1;
          state_nxt = ST_DELIVER;
        end else if (ack_evt) begin
          state_nxt = ST_WAIT_RSP;
        end else if (timeout) begin
          timeout_fire = 1'b1;
          state_nxt    = ST_DELIVER;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_evt) begin
          capture   = 1'b1;
          state_nxt = ST_DELIVER;
        end else if (timeout) begin
          timeout_fire = 1'b1;
          state_nxt    = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWNER_USB;
      last_served_q <= OWNER_EXT;
      p_data_q      <= '0;
      rsp_data_q    <= '0;
      wr_flk_q      <= 1'b0;
      rd_flk_q      <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (grant_usb || grant_ext) begin
        p_data_q <= grant_usb ? usb_req_data_i : ext_req_data_i;
        wr_flk_q <= ~wr_flk_q;
        owner_q  <= grant_ext ? OWNER_EXT : OWNER_USB;
      end
      if (capture) begin
        rsp_data_q <= p_data_i;
        rd_flk_q   <= ~rd_flk_q;
      end
      if (timeout_fire) rsp_data_q <= '0;
      if (state_q == ST_DELIVER && rsp_ready) last_served_q <= owner_q;
    end
  end

`ifdef MBOX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             rsp_err_q;

  // Any state change restarts the count, so SEND and WAIT_RSP each get a full budget.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_nxt != state_q) tmo_cnt_q <= '0;
      else if (state_q == ST_SEND || state_q == ST_WAIT_RSP) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (timeout_fire) rsp_err_q <= 1'b1;
      else if (capture) rsp_err_q <= 1'b0;
    end
  end

  assign timeout = (state_q == ST_SEND || state_q == ST_WAIT_RSP) &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign usb_req_ready_o = grant_usb;
  assign ext_req_ready_o = grant_ext;
  assign usb_rsp_valid_o = (state_q == ST_DELIVER) && (owner_q == OWNER_USB);
  assign ext_rsp_valid_o = (state_q == ST_DELIVER) && (owner_q == OWNER_EXT);
  assign usb_rsp_data_o  = (owner_q == OWNER_USB) ? rsp_data_q : '0;
  assign ext_rsp_data_o  = (owner_q == OWNER_EXT) ? rsp_data_q : '0;
  assign usb_rsp_err_o   = (owner_q == OWNER_USB) && rsp_err;
  assign ext_rsp_err_o   = (owner_q == OWNER_EXT) && rsp_err;
  assign p_data_o        = p_data_q;
  assign p_wr_flicker_o  = wr_flk_q;
  assign p_rd_flicker_o  = rd_flk_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign owner_o         = owner_q;

endmodule

// File: tb/tb_usb_pulpino_mbox_ctrl.sv
// tb/tb_usb_pulpino_mbox_ctrl.sv - randomized directed bench for the USB/EXT Pulpino mailbox
module tb_usb_pulpino_mbox_ctrl;

  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          usb_req_valid_i, usb_req_ready_o, usb_rsp_valid_o, usb_rsp_ready_i, usb_rsp_err_o;
  logic [DW-1:0] usb_req_data_i, usb_rsp_data_o;
  logic          ext_req_valid_i, ext_req_ready_o, ext_rsp_valid_o, ext_rsp_ready_i, ext_rsp_err_o;
  logic [DW-1:0] ext_req_data_i, ext_rsp_data_o;
  logic [DW-1:0] p_data_o, p_data_i;
  logic          p_wr_flicker_o, p_rd_flicker_i, p_wr_flicker_i, p_rd_flicker_o;
  logic          busy_o, owner_o;

  int   checks = 0;
  int   errors = 0;
  logic last_served;
  logic exp_wr_flk, exp_rd_flk;

  always #5 clk = ~clk;

  usb_pulpino_mbox_ctrl #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_i(reset_i),
    .usb_req_valid_i(usb_req_valid_i), .usb_req_ready_o(usb_req_ready_o), .usb_req_data_i(usb_req_data_i),
    .usb_rsp_valid_o(usb_rsp_valid_o), .usb_rsp_ready_i(usb_rsp_ready_i), .usb_rsp_data_o(usb_rsp_data_o),
    .usb_rsp_err_o(usb_rsp_err_o),
    .ext_req_valid_i(ext_req_valid_i), .ext_req_ready_o(ext_req_ready_o), .ext_req_data_i(ext_req_data_i),
    .ext_rsp_valid_o(ext_rsp_valid_o), .ext_rsp_ready_i(ext_rsp_ready_i), .ext_rsp_data_o(ext_rsp_data_o),
    .ext_rsp_err_o(ext_rsp_err_o),
    .p_data_o(p_data_o), .p_wr_flicker_o(p_wr_flicker_o), .p_rd_flicker_i(p_rd_flicker_i),
    .p_data_i(p_data_i), .p_wr_flicker_i(p_wr_flicker_i), .p_rd_flicker_o(p_rd_flicker_o),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_owner"}, owner_o, 0);
    chk({tag, "_pdata"}, p_data_o, 0);
    chk({tag, "_wrflk"}, p_wr_flicker_o, 0);
    chk({tag, "_rdflk"}, p_rd_flicker_o, 0);
    chk({tag, "_rspv"}, {usb_rsp_valid_o, ext_rsp_valid_o}, 0);
    chk({tag, "_rspd"}, {usb_rsp_data_o, ext_rsp_data_o}, 0);
    chk({tag, "_rspe"}, {usb_rsp_err_o, ext_rsp_err_o}, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rspv"}, {usb_rsp_valid_o, ext_rsp_valid_o}, 0);
  endtask

  // Model: winner is the sole requester, or on a tie the one not served last.
  task automatic xfer(input logic ru, input logic re, input logic [DW-1:0] ub, input logic [DW-1:0] eb,
                      input logic [DW-1:0] rb, input logic same, input int ack_dly, input int rsp_dly,
                      input int hold, input string tag);
    logic          own;
    logic [DW-1:0] sent;
    own  = (ru && re) ? ~last_served : ~ru;
    sent = own ? eb : ub;
    @(negedge clk);
    usb_req_valid_i = ru; usb_req_data_i = ub;
    ext_req_valid_i = re; ext_req_data_i = eb;
    #1;
    chk({tag, "_usb_ready"}, usb_req_ready_o, !own);
    chk({tag, "_ext_ready"}, ext_req_ready_o, own);
    @(negedge clk);
    usb_req_valid_i = 1'b0; ext_req_valid_i = 1'b0;
    exp_wr_flk = ~exp_wr_flk;
    chk({tag, "_busy"}, busy_o, 1);
    chk({tag, "_owner"}, owner_o, own);
    chk({tag, "_pdata"}, p_data_o, sent);
    chk({tag, "_wrflk"}, p_wr_flicker_o, exp_wr_flk);
    p_data_i = rb;
    if (same) begin
      p_rd_flicker_i = ~p_rd_flicker_i;
      p_wr_flicker_i = ~p_wr_flicker_i;
    end else begin
      repeat (ack_dly - 1) @(negedge clk);
      p_rd_flicker_i = ~p_rd_flicker_i;
      repeat (rsp_dly) @(negedge clk);
      chk({tag, "_wait_busy"}, busy_o, 1);
      chk({tag, "_wait_rspv"}, {usb_rsp_valid_o, ext_rsp_valid_o}, 0);
      p_wr_flicker_i = ~p_wr_flicker_i;
    end
    @(negedge clk);
    exp_rd_flk = ~exp_rd_flk;
    chk({tag, "_rspv"}, {usb_rsp_valid_o, ext_rsp_valid_o}, own ? 2'b01 : 2'b10);
    chk({tag, "_rspd"}, own ? ext_rsp_data_o : usb_rsp_data_o, rb);
    chk({tag, "_rspe"}, {usb_rsp_err_o, ext_rsp_err_o}, 0);
    chk({tag, "_rdflk"}, p_rd_flicker_o, exp_rd_flk);
    chk({tag, "_wrflk2"}, p_wr_flicker_o, exp_wr_flk);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, own ? ext_rsp_valid_o : usb_rsp_valid_o, 1);
      chk({tag, "_hold_d"}, own ? ext_rsp_data_o : usb_rsp_data_o, rb);
    end
    if (own) ext_rsp_ready_i = 1'b1; else usb_rsp_ready_i = 1'b1;
    @(negedge clk);
    usb_rsp_ready_i = 1'b0; ext_rsp_ready_i = 1'b0;
    chk_idle({tag, "_done"});
    last_served = own;
  endtask

  initial begin
    int  n;
    logic ru, re;
    reset_i = 1'b1;
    usb_req_valid_i = 0; usb_req_data_i = '0; usb_rsp_ready_i = 0;
    ext_req_valid_i = 0; ext_req_data_i = '0; ext_rsp_ready_i = 0;
    p_rd_flicker_i = 1'b1; p_wr_flicker_i = 1'b0; p_data_i = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_ready", {usb_req_ready_o, ext_req_ready_o}, 0);
    reset_i = 1'b0;
    last_served = 1'b1; exp_wr_flk = 1'b0; exp_rd_flk = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    xfer(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 2, 2, 0, "tie1");
    xfer(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1, 1, 1, "tie2");
    xfer(1, 0, 8'h5A, 8'h00, 8'hA5, 0, 3, 3, 2, "usb_5a");
    xfer(0, 1, 8'($urandom), 8'($urandom), 8'($urandom), 1, 1, 1, 1, "same_cyc");

    @(negedge clk);
    p_wr_flicker_i = ~p_wr_flicker_i;
    repeat (3) begin
      @(negedge clk);
      chk_idle("spurious");
    end
    xfer(1, 0, 8'($urandom), 8'($urandom), 8'($urandom), 0, 2, 3, 0, "after_spur");

    @(negedge clk);
    usb_req_valid_i = 1'b1; usb_req_data_i = 8'($urandom);
    @(negedge clk);
    usb_req_valid_i = 1'b0;
    p_rd_flicker_i = ~p_rd_flicker_i;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy_o, 1);
    reset_i = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    reset_i = 1'b0;
    last_served = 1'b1; exp_wr_flk = 1'b0; exp_rd_flk = 1'b0;
    p_wr_flicker_i = ~p_wr_flicker_i;
    repeat (3) begin
      @(negedge clk);
      chk_idle("aborted");
    end
    xfer(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 2, 2, 1, "after_rst");

`ifdef MBOX_TIMEOUT_EN
    @(negedge clk);
    ext_req_valid_i = 1'b1; ext_req_data_i = 8'($urandom);
    #1 chk("tmo_ready", ext_req_ready_o, 1);
    @(negedge clk);
    ext_req_valid_i = 1'b0;
    exp_wr_flk = ~exp_wr_flk;
    chk("tmo_busy", busy_o, 1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ext_rsp_valid_o) begin
        n = i;
        break;
      end
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_data", ext_rsp_data_o, 0);
    chk("tmo_err", ext_rsp_err_o, 1);
    chk("tmo_rdflk", p_rd_flicker_o, exp_rd_flk);
    ext_rsp_ready_i = 1'b1;
    @(negedge clk);
    ext_rsp_ready_i = 1'b0;
    chk_idle("tmo_done");
    last_served = 1'b1;
`endif

    for (int k = 0; k < 10; k++) begin
      ru = 1'($urandom);
      re = 1'($urandom);
      if (!ru && !re) ru = 1'b1;
      xfer(ru, re, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
           int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
